crc_128_dec: RTL

Multi-cycle CRC-6 checker for 134-bit codewords produced by `crc_128_enc`, which sends 128 data bits followed by 6 CRC bits. It accepts one codeword through a ready/enable handshake. It shifts the full codeword through a STEP-bit-per-cycle CRC-6 LFSR, then presents the recovered data, the 6-bit syndrome and a pass/fail flag with a one-cycle valid pulse. It sits on the receive side of the link, directly downstream of the channel or storage that carried the encoder output.

---
 rtl/crc_128_pkg.sv | 14 +
 rtl/crc_6_step.sv | 24 ++
 rtl/crc_128_dec.sv | 88 ++++++++
 3 files changed

// File: rtl/crc_128_pkg.sv
// Constants and FSM state type shared by the CRC-6 codeword encoder and decoder.
// Generator x^6+x+1 (CRC-6-ITU), MSB-first, init 0, no reflection, no final XOR.
package crc_128_pkg;
    localparam int DATA_W = 128;
    localparam int CRC_W  = 6;
    localparam int CODE_W = DATA_W + CRC_W;
    localparam logic [CRC_W-1:0] POLY = 6'h03;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/crc_6_step.sv
// Combinational STEP-bit CRC-6 long-division step, MSB-first; zero latency, no handshake.
// din[STEP-1] is the earliest bit of the stream and enters the remainder first.
module crc_6_step
    import crc_128_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic [CRC_W-1:0] rem,
    input  logic [STEP-1:0]  din,
    output logic [CRC_W-1:0] rem_next
);

    logic [CRC_W-1:0] r;

    // Each bit: r = (r * x + b) mod POLY, with the x^6 term implicit.
    always_comb begin
        r = rem;
        for (int i = STEP - 1; i >= 0; i--) begin
            r = {r[CRC_W-2:0], din[i]} ^ (r[CRC_W-1] ? POLY : '0);
        end
        rem_next = r;
    end

endmodule

// File: rtl/crc_128_dec.sv
// CRC-6 checker for 134-bit codewords; result valid CODE_W/STEP+2 edges after accept.
// Single-entry: o_ready is high only in IDLE, enable is ignored while busy.
module crc_128_dec
    import crc_128_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [0:CODE_W-1]   i_code,
    output logic                o_ready,
    output logic [0:DATA_W-1]   o_data,
    output logic [CRC_W-1:0]    o_syndrome,
    output logic                o_crc_ok,
    output logic                o_valid
);

    localparam int CNT_W = $clog2(CODE_W + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CODE_W);
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(STEP);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 67)) begin : g_bad_step
            $error("crc_128_dec: STEP must be 1, 2 or 67");
        end
    endgenerate

    state_t              state;
    logic [CODE_W-1:0]   sreg;
    logic [0:DATA_W-1]   data_q;
    logic [CRC_W-1:0]    rem;
    logic [CRC_W-1:0]    rem_next;
    logic [CNT_W-1:0]    cnt;

    // sreg[CODE_W-1] holds i_code[0], so the leading bits sit at the top.
    crc_6_step #(.STEP(STEP)) u_step (
        .rem      (rem),
        .din      (sreg[CODE_W-1 -: STEP]),
        .rem_next (rem_next)
    );

    assign o_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            data_q     <= '0;
            rem        <= '0;
            cnt        <= '0;
            o_data     <= '0;
            o_syndrome <= '0;
            o_crc_ok   <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        sreg   <= i_code;
                        data_q <= i_code[0:DATA_W-1];
                        rem    <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    rem  <= rem_next;
                    sreg <= sreg << STEP;
                    cnt  <= cnt + CNT_INC;
                    if (cnt + CNT_INC == CNT_END) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_data     <= data_q;
                    o_syndrome <= rem;
                    o_crc_ok   <= (rem == '0);
                    o_valid    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
